// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
//   Shared constants and helpers for the serial pattern detector.
//   - DEF_PAT_W     : default pattern length in bits
//   - DEF_CNT_W     : default match counter width
//   - DEF_RESET_PAT : default pattern loaded at reset (oldest bit is the MSB)
//   - sat_inc()     : saturating increment for counters up to 32 bits wide
// ---------------------------------------------------------------------------
package seq_detect_pkg;

  localparam int          DEF_PAT_W     = 4;
  localparam int          DEF_CNT_W     = 8;
  localparam logic [3:0]  DEF_RESET_PAT = 4'b1011;

  // Increment v, but never past the largest value that fits in w bits.
  // Inputs and result are carried at 32 bits; callers truncate to w.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage : seq_detect_pkg

// File: rtl/seq_detect_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear. Clear is applied before
//   the increment, so clr and inc together leave the counter at 1.
//   Ports:
//     clk     in  1 : rising-edge clock
//     reset_n in  1 : asynchronous active-low reset (counter -> 0)
//     clr     in  1 : synchronous clear
//     inc     in  1 : count request; holds at all-ones once reached
//     q       out W : current count
// ---------------------------------------------------------------------------
module sat_counter
  import seq_detect_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // sat_inc works on 32-bit values, so wider counters are not supported.
  generate
    if (W < 1 || W > 32) begin : g_bad_width
      $error("sat_counter: W must be in 1..32");
    end
  endgenerate

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= inc ? W'(1) : '0;
    end else if (inc) begin
      r_q <= W'(sat_inc(32'(r_q), W));
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/seq_detect.sv
// ---------------------------------------------------------------------------
// seq_detect
//   Serial pattern detector. One bit of 'a' is shifted into a history
//   register on every cycle with en=1; when the newest PAT_W accepted bits
//   equal the active pattern, a one-cycle registered pulse is raised on y
//   and the saturating match counter advances.
//   Ports:
//     clk       in  1     : rising-edge clock
//     reset_n   in  1     : asynchronous active-low reset
//     en        in  1     : sample strobe for a
//     a         in  1     : serial data bit
//     overlap   in  1     : 1 = matches may share bits, 0 = restart after match
//     pat_load  in  1     : load pat_in as the new pattern (beats sampling)
//     pat_in    in  PAT_W : new pattern, bit PAT_W-1 oldest, bit 0 newest
//     cnt_clr   in  1     : synchronous clear of match_cnt
//     y         out 1     : match pulse
//     match_cnt out CNT_W : saturating number of matches
//     pattern   out PAT_W : active pattern
// ---------------------------------------------------------------------------
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W     = DEF_PAT_W,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEF_RESET_PAT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             a,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern
);

  generate
    if (PAT_W < 2) begin : g_bad_pat_w
      $error("seq_detect: PAT_W must be at least 2");
    end
  endgenerate

  // fill counts accepted bits since the last reset/load/non-overlap match,
  // saturating at PAT_W; it is the only state the detector needs.
  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_y;

  logic              w_sample;
  logic [PAT_W-1:0]  w_hist_next;
  logic [FILL_W-1:0] w_fill_next;
  logic              w_match;

  // A load in the same cycle swallows the bit on a.
  assign w_sample    = en & ~pat_load;
  assign w_hist_next = {r_hist[PAT_W-2:0], a};
  assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + FILL_W'(1));

  // The history is only trusted once PAT_W bits have arrived, which stops
  // the zero-initialised register from matching an all-zeros pattern early.
  assign w_match = w_sample && (w_fill_next == FILL_FULL) &&
                   (w_hist_next == r_pattern);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= RESET_PAT;
      r_y       <= 1'b0;
    end else if (pat_load) begin
      r_pattern <= pat_in;
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
    end else if (en) begin
      r_hist <= w_hist_next;
      // Non-overlap mode forgets the matched bits by restarting the fill
      // count; hist keeps shifting but cannot match until refilled.
      r_fill <= (w_match && !overlap) ? '0 : w_fill_next;
      r_y    <= w_match;
    end else begin
      r_y <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (w_match),
    .q       (match_cnt)
  );

  assign y       = r_y;
  assign pattern = r_pattern;

endmodule : seq_detect

// File: tb/tb_seq_detect.sv
module tb_seq_detect;

  localparam int         PW   = 4;
  localparam int         CW   = 2;
  localparam logic [3:0] RPAT = 4'b1011;
  localparam int         CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en, a, overlap, pat_load, cnt_clr;
  logic [PW-1:0] pat_in;
  logic          y;
  logic [CW-1:0] match_cnt;
  logic [PW-1:0] pattern;

  always #5 clk = ~clk;

  seq_detect #(
    .PAT_W     (PW),
    .CNT_W     (CW),
    .RESET_PAT (RPAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .a         (a),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .y         (y),
    .match_cnt (match_cnt),
    .pattern   (pattern)
  );

  typedef struct {
    int            id;
    logic          y;
    int            cnt;
    logic [PW-1:0] pat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   txn   = 0;

  // Reference model: the list of accepted bits that may still be part of
  // a match, the active pattern, and the match count as an integer.
  bit            m_bits[$];
  logic [PW-1:0] m_pat;
  int            m_cnt;

  function automatic void model_reset();
    m_bits.delete();
    m_pat = RPAT;
    m_cnt = 0;
  endfunction

  function automatic logic model_step(input logic s_en, input logic s_a,
                                      input logic s_ov, input logic s_ld,
                                      input logic [PW-1:0] s_pin,
                                      input logic s_clr);
    int v;
    logic hit;
    hit = 1'b0;
    if (s_clr) m_cnt = 0;
    if (s_ld) begin
      m_pat = s_pin;
      m_bits.delete();
    end else if (s_en) begin
      m_bits.push_back(s_a);
      if (m_bits.size() > PW) void'(m_bits.pop_front());
      if (m_bits.size() == PW) begin
        v = 0;
        foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
        if (v == int'(m_pat)) begin
          hit = 1'b1;
          m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          if (!s_ov) m_bits.delete();
        end
      end
    end
    return hit;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the queue.
  task automatic cycle(input logic c_en, input logic c_a, input logic c_ov,
                       input logic c_ld, input logic [PW-1:0] c_pin,
                       input logic c_clr);
    logic ey;
    en = c_en; a = c_a; overlap = c_ov; pat_load = c_ld;
    pat_in = c_pin; cnt_clr = c_clr;
    @(posedge clk);
    #1;
    ey = model_step(c_en, c_a, c_ov, c_ld, c_pin, c_clr);
    exp_q.push_back('{id: txn, y: ey, cnt: m_cnt, pat: m_pat});
    txn++;
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], ov, 1'b0, '0, 1'b0);
  endtask

  // Monitor: every falling edge, compare outputs against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d: y=%0b cnt=%0d pat=%b (exp y=%0b cnt=%0d pat=%b)",
                 e.id, y, match_cnt, pattern, e.y, e.cnt, e.pat);
        check("y", int'(y), int'(e.y));
        check("match_cnt", int'(match_cnt), e.cnt);
        check("pattern", int'(pattern), int'(e.pat));
      end
    end
  end

  initial begin
    logic ey;
    reset_n = 1'b0; en = 0; a = 0; overlap = 0; pat_load = 0; cnt_clr = 0;
    pat_in = '0;
    model_reset();
    #12;
    check("reset_y", int'(y), 0);
    check("reset_cnt", int'(match_cnt), 0);
    check("reset_pattern", int'(pattern), int'(RPAT));
    @(negedge clk);
    reset_n = 1'b1;

    // First match after PAT_W samples.
    feed(32'b1011, 4, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    // Overlap vs non-overlap on 1,0,1,1,0,1,1.
    feed(32'b1011011, 7, 1'b1);
    feed(32'b1011011, 7, 1'b0);
    // Enable gaps with a toggling during them.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    // Saturation: five more matches, then clear coinciding with a match.
    for (int k = 0; k < 5; k++) feed(32'b1011, 4, 1'b0);
    feed(32'b101, 3, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    // Pattern load after two bits; a is set to a matching-looking value.
    feed(32'b01, 2, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    feed(32'b110, 3, 1'b0);
    feed(32'b0110, 4, 1'b0);
    // Async reset while y is high, between clock edges.
    feed(32'b011, 3, 1'b0);
    @(negedge clk);
    #1;
    en = 1'b1; a = 1'b0; overlap = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    ey = model_step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("pre_reset_y", int'(y), int'(ey));
    check("pre_reset_cnt", int'(match_cnt), m_cnt);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_y", int'(y), 0);
    check("async_reset_cnt", int'(match_cnt), 0);
    check("async_reset_pattern", int'(pattern), int'(RPAT));
    @(negedge clk);
    reset_n = 1'b1;
    feed(32'b11, 2, 1'b0);
    feed(32'b11, 2, 1'b0);
    // Periodic pattern with overlap gives back-to-back pulses.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    feed(32'b111111, 6, 1'b1);

    // Randomised traffic.
    for (int p = 0; p < 1200; p++) begin
      logic r_en, r_ld, r_clr, r_ov;
      logic [PW-1:0] r_pin;
      r_en  = ($urandom_range(0, 9) < 8);
      r_ld  = ($urandom_range(0, 59) == 0);
      r_clr = ($urandom_range(0, 29) == 0);
      r_ov  = ($urandom_range(0, 7) < 5);
      r_pin = PW'($urandom_range(0, (1 << PW) - 1));
      cycle(r_en, 1'($urandom_range(0, 1)), r_ov, r_ld, r_pin, r_clr);
    end
    en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_detect
